prim_sram_dp_responder: RTL and testbench
=========================================

# prim_sram_dp_responder

Dual-clock SRAM responder model/controller that terminates the two SRAM request ports driven by an SRAM-backed async FIFO. The write port (`w_*`, `clk_wr_i`) owns the storage array and services masked writes. The read port (`r_*`, `clk_rd_i`) services read-only requests with fixed one-cycle latency. Both ports use programmable grant back-pressure and error signalling, so the FIFO can be exercised against a realistic responder in simulation and FPGA builds.

## Interface
- `SramAw`, 16, address width
- `SramDw`, 32, data/mask width
- `Depth`, 16, entries in array; power of two, ≥ 4
- `SramBaseAddr`, 'h0, first valid address; range is [Base, Base+Depth)
- `WrGntPattern`, 8'hFF, write-port grant rotation pattern; bit 0 is used first
- `RdGntPattern`, 8'hFF, read-port grant rotation pattern
- `clk_wr_i`  in  1  write-port clock; also the array clock
- `rst_wr_ni`  in  1  write-domain reset, asynchronous, active-low
- `clk_rd_i`  in  1  read-port clock
- `rst_rd_ni`  in  1  read-domain reset, asynchronous, active-low
- `w_sram_req_i`, `w_sram_write_i`  in  1  write-port request, op
- `w_sram_addr_i`  in  SramAw  write-port address
- `w_sram_wdata_i`, `w_sram_wmask_i`  in  SramDw  write data, bit mask
- `w_sram_gnt_o`  out  1  write-port grant
- `w_sram_rvalid_o`  out  1  write-port read response valid
- `w_sram_rdata_o`  out  SramDw  write-port read data
- `w_sram_rerror_o`  out  2  write-port response error
- `r_sram_req_i`, `r_sram_write_i`  in  1  read-port request, op
- `r_sram_addr_i`  in  SramAw  read-port address
- `r_sram_wdata_i`, `r_sram_wmask_i`  in  SramDw  ignored
- `r_sram_gnt_o`, `r_sram_rvalid_o`  out  1  read-port grant, response valid
- `r_sram_rdata_o`  out  SramDw  read data
- `r_sram_rerror_o`  out  2  read-port response error
- `w_err_cnt_o`  out  8  write-port error count, saturating, `clk_wr_i` domain
- `r_err_cnt_o`  out  8  read-port error count, saturating, `clk_rd_i` domain

## Operation
- **Grant.** Each port holds an 8-bit pattern register, reset to its parameter, that rotates right by one every cycle of its own clock. `gnt_o` = pattern[0]. Grant is independent of `req`.
- **Accept.** A request is accepted when `req & gnt`. Offset = `addr - SramBaseAddr`. The access is in range when offset < Depth.
- **Write port, write.** For an accepted in-range write, `mem[offset] <= (mem & ~wmask) | (wdata & wmask)` at the next `clk_wr_i` edge. Writes produce no rvalid. An out-of-range write is dropped and increments `w_err_cnt_o`.
- **Write port, read.** Handled the same way as a read-port read, on `clk_wr_i`.
- **Read port, read.** An accepted read in cycle N gives `rvalid=1` in cycle N+1, with `rdata = mem[offset]` sampled at the N→N+1 `clk_rd_i` edge.
- **Read port, write.** Granted, produces no rvalid, leaves the array unchanged, and increments `r_err_cnt_o`.
- **Out-of-range read.** Still returns rvalid, with `rdata = 0` and `rerror = 2'b10`, and increments the port's error counter.
- **Error codes.** `rerror` is 2'b00 for OK and 2'b10 for address error. 2'b01 is reserved for ECC and is never driven.
- **Error counters.** They saturate at 8'hFF.
- **Array reset.** The array is not reset.
- **Reset values.** `gnt` = pattern param bit 0; `rvalid` = 0; `rdata` = 0; `rerror` = 0; error counters = 0.

## Timing
- Read latency is exactly one cycle of the port's clock. There is no stall after grant. rvalid lasts one cycle per accepted read.
- `rdata`/`rerror` are registered and hold 0 whenever `rvalid` = 0.
- A write-port read that follows a write to the same offset in the next `clk_wr_i` cycle returns the new data.
- Read port vs write port on the same offset, with the read sampled within one `clk_rd_i` period of the write edge: rdata is undefined. The FIFO's pointer synchronisation excludes this case, and the bench must not check it.
- Each reset affects only its own port. Asserting `rst_rd_ni` mid-transaction drops the pending rvalid; the array and the write port are unaffected. Asserting `rst_wr_ni` resets the write port only; array contents persist.

## Structure
- Package `prim_sram_resp_pkg` holds:
  - `sram_err_e`: `SramErrNone` = 2'b00, `SramErrEcc` = 2'b01, `SramErrAddr` = 2'b10.
  - `ErrCntW` = 8.
- Sub-module `prim_sram_resp_port` implements the pattern rotator, grant, range check, response register and saturating error counter. It is instantiated twice, once per port.
- The top level holds the array and the write-mask update.

## Test plan
- **Reset.** Release both resets with `RdGntPattern` = 8'hA5 → `r_sram_gnt_o` follows 1,0,1,0,0,1,0,1 and repeats; all rvalid = 0; both counters = 0.
- **Masked write.** Write 32'h1234_5678 to Base+3 with full mask, then write 32'hA5A5_0000 with mask 32'hFFFF_0000. Read port reads Base+3 → rvalid one cycle after grant, `rdata` = 32'hA5A5_5678, `rerror` = 0.
- **Out-of-range read.** Read-port read of Base+Depth → rvalid with `rdata` = 0, `rerror` = 2'b10, `r_err_cnt_o` = 1.
- **Throttled grant.** `WrGntPattern` = 8'h55 with `w_sram_req` held for 8 cycles → exactly 4 accepted writes, to the addresses presented in grant cycles only.
- **Error counter saturation.** 300 read-port write requests → no rvalid, array unchanged, `r_err_cnt_o` saturates at 8'hFF.
- **Read reset mid-transaction.** Assert `rst_rd_ni` in the cycle after an accepted read → no rvalid appears. A concurrent write-port write still commits, and a later read-port read returns it.

Source files
------------

// File: rtl/prim_sram_resp_pkg.sv
// prim_sram_resp_pkg: shared types and constants for the dual-port SRAM responder.
package prim_sram_resp_pkg;

    typedef enum logic [1:0] {
        SramErrNone = 2'b00,
        SramErrEcc  = 2'b01,
        SramErrAddr = 2'b10
    } sram_err_e;

    localparam int ErrCntW = 8;

endpackage

// File: rtl/prim_sram_resp_port.sv
// prim_sram_resp_port: one SRAM request port (grant rotator, range check,
// one-cycle read response register, saturating error counter).
// Ports: clk_i/rst_ni (async active-low); req_i/write_i/addr_i request;
// mem_rdata_i array word at idx_o; gnt_o grant; rvalid_o/rdata_o/rerror_o
// registered response; err_cnt_o error count; wr_en_o/idx_o array write strobe.
module prim_sram_resp_port
    import prim_sram_resp_pkg::*;
#(
    parameter int             AW         = 16,
    parameter int             DW         = 32,
    parameter int             Depth      = 16,
    parameter logic [AW-1:0]  BaseAddr   = '0,
    parameter logic [7:0]     GntPattern = 8'hFF,
    parameter bit             WriteEn    = 1'b1,
    localparam int            IdxW       = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               req_i,
    input  logic               write_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [DW-1:0]      mem_rdata_i,
    output logic               gnt_o,
    output logic               rvalid_o,
    output logic [DW-1:0]      rdata_o,
    output logic [1:0]         rerror_o,
    output logic [ErrCntW-1:0] err_cnt_o,
    output logic               wr_en_o,
    output logic [IdxW-1:0]    idx_o
);

    logic [7:0]         pat_q, pat_d;
    logic               rvalid_q, rvalid_d;
    logic [DW-1:0]      rdata_q, rdata_d;
    sram_err_e          rerror_q, rerror_d;
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0]      offset;
    logic               in_range, acc, rd_acc, err;

    always_comb begin
        pat_d     = {pat_q[0], pat_q[7:1]};
        acc       = req_i & pat_q[0];
        offset    = addr_i - BaseAddr;
        in_range  = offset < AW'(Depth);
        rd_acc    = acc & ~write_i;
        // Writes on a read-only port count as errors even when in range.
        err       = acc & (~in_range | (write_i & ~WriteEn));
        rvalid_d  = rd_acc;
        rdata_d   = (rd_acc & in_range) ? mem_rdata_i : '0;
        rerror_d  = (rd_acc & ~in_range) ? SramErrAddr : SramErrNone;
        err_cnt_d = (err & ~&err_cnt_q) ? err_cnt_q + ErrCntW'(1) : err_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pat_q     <= GntPattern;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rerror_q  <= SramErrNone;
            err_cnt_q <= '0;
        end else begin
            pat_q     <= pat_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rerror_q  <= rerror_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign gnt_o     = pat_q[0];
    assign rvalid_o  = rvalid_q;
    assign rdata_o   = rdata_q;
    assign rerror_o  = rerror_q;
    assign err_cnt_o = err_cnt_q;
    assign wr_en_o   = acc & write_i & in_range & WriteEn;
    assign idx_o     = offset[IdxW-1:0];

endmodule

// File: rtl/prim_sram_dp_responder.sv
// prim_sram_dp_responder: dual-clock SRAM responder terminating an async FIFO's
// two SRAM ports. Holds the (unreset) array on clk_wr_i with masked writes.
// Ports: w_* write port on clk_wr_i/rst_wr_ni; r_* read-only port on
// clk_rd_i/rst_rd_ni; w_err_cnt_o/r_err_cnt_o per-domain saturating error counts.
module prim_sram_dp_responder
    import prim_sram_resp_pkg::*;
#(
    parameter int                SramAw       = 16,
    parameter int                SramDw       = 32,
    parameter int                Depth        = 16,
    parameter logic [SramAw-1:0] SramBaseAddr = '0,
    parameter logic [7:0]        WrGntPattern = 8'hFF,
    parameter logic [7:0]        RdGntPattern = 8'hFF
) (
    input  logic               clk_wr_i,
    input  logic               rst_wr_ni,
    input  logic               clk_rd_i,
    input  logic               rst_rd_ni,
    input  logic               w_sram_req_i,
    input  logic               w_sram_write_i,
    input  logic [SramAw-1:0]  w_sram_addr_i,
    input  logic [SramDw-1:0]  w_sram_wdata_i,
    input  logic [SramDw-1:0]  w_sram_wmask_i,
    output logic               w_sram_gnt_o,
    output logic               w_sram_rvalid_o,
    output logic [SramDw-1:0]  w_sram_rdata_o,
    output logic [1:0]         w_sram_rerror_o,
    input  logic               r_sram_req_i,
    input  logic               r_sram_write_i,
    input  logic [SramAw-1:0]  r_sram_addr_i,
    input  logic [SramDw-1:0]  r_sram_wdata_i,
    input  logic [SramDw-1:0]  r_sram_wmask_i,
    output logic               r_sram_gnt_o,
    output logic               r_sram_rvalid_o,
    output logic [SramDw-1:0]  r_sram_rdata_o,
    output logic [1:0]         r_sram_rerror_o,
    output logic [ErrCntW-1:0] w_err_cnt_o,
    output logic [ErrCntW-1:0] r_err_cnt_o
);

    localparam int IdxW = $clog2(Depth);

    logic [SramDw-1:0] mem_q [Depth];
    logic [SramDw-1:0] mem_wdata, w_mem_rdata, r_mem_rdata;
    logic [IdxW-1:0]   w_idx, r_idx;
    logic              w_wr_en;
    logic              unused_r;

    // The read port never writes; its data/mask and write strobe are sinks.
    assign unused_r = ^{r_sram_wdata_i, r_sram_wmask_i};

    // Read port samples the array across domains; the FIFO's pointer
    // synchronisation keeps it away from words being written.
    assign w_mem_rdata = mem_q[w_idx];
    assign r_mem_rdata = mem_q[r_idx];

    always_comb begin
        mem_wdata = (mem_q[w_idx] & ~w_sram_wmask_i) | (w_sram_wdata_i & w_sram_wmask_i);
    end

    always_ff @(posedge clk_wr_i) begin
        if (w_wr_en) mem_q[w_idx] <= mem_wdata;
    end

    prim_sram_resp_port #(
        .AW(SramAw), .DW(SramDw), .Depth(Depth), .BaseAddr(SramBaseAddr),
        .GntPattern(WrGntPattern), .WriteEn(1'b1)
    ) u_wr_port (
        .clk_i(clk_wr_i), .rst_ni(rst_wr_ni),
        .req_i(w_sram_req_i), .write_i(w_sram_write_i), .addr_i(w_sram_addr_i),
        .mem_rdata_i(w_mem_rdata),
        .gnt_o(w_sram_gnt_o), .rvalid_o(w_sram_rvalid_o), .rdata_o(w_sram_rdata_o),
        .rerror_o(w_sram_rerror_o), .err_cnt_o(w_err_cnt_o),
        .wr_en_o(w_wr_en), .idx_o(w_idx)
    );

    logic unused_r_wr_en;

    prim_sram_resp_port #(
        .AW(SramAw), .DW(SramDw), .Depth(Depth), .BaseAddr(SramBaseAddr),
        .GntPattern(RdGntPattern), .WriteEn(1'b0)
    ) u_rd_port (
        .clk_i(clk_rd_i), .rst_ni(rst_rd_ni),
        .req_i(r_sram_req_i), .write_i(r_sram_write_i), .addr_i(r_sram_addr_i),
        .mem_rdata_i(r_mem_rdata),
        .gnt_o(r_sram_gnt_o), .rvalid_o(r_sram_rvalid_o), .rdata_o(r_sram_rdata_o),
        .rerror_o(r_sram_rerror_o), .err_cnt_o(r_err_cnt_o),
        .wr_en_o(unused_r_wr_en), .idx_o(r_idx)
    );

endmodule

// File: tb/tb_prim_sram_dp_responder.sv
// tb_prim_sram_dp_responder: randomized + directed bench with a behavioural model.
module tb_prim_sram_dp_responder;

    localparam int          Depth = 16;
    localparam logic [15:0] Base  = 16'h0100;
    localparam logic [7:0]  WrPat = 8'h55;
    localparam logic [7:0]  RdPat = 8'hA5;
    localparam int          RdPer = 14;

    logic        clk_wr_i = 0, clk_rd_i = 0, rst_wr_ni = 0, rst_rd_ni = 0;
    logic        w_sram_req_i = 0, w_sram_write_i = 0, r_sram_req_i = 0, r_sram_write_i = 0;
    logic [15:0] w_sram_addr_i = 0, r_sram_addr_i = 0;
    logic [31:0] w_sram_wdata_i = 0, w_sram_wmask_i = 0, r_sram_wdata_i = 0, r_sram_wmask_i = 0;
    logic        w_sram_gnt_o, w_sram_rvalid_o, r_sram_gnt_o, r_sram_rvalid_o;
    logic [31:0] w_sram_rdata_o, r_sram_rdata_o;
    logic [1:0]  w_sram_rerror_o, r_sram_rerror_o;
    logic [7:0]  w_err_cnt_o, r_err_cnt_o;

    int tests = 0, fails = 0;

    always #5 clk_wr_i = ~clk_wr_i;
    always #7 clk_rd_i = ~clk_rd_i;

    prim_sram_dp_responder #(
        .SramAw(16), .SramDw(32), .Depth(Depth), .SramBaseAddr(Base),
        .WrGntPattern(WrPat), .RdGntPattern(RdPat)
    ) dut (
        .clk_wr_i(clk_wr_i), .rst_wr_ni(rst_wr_ni), .clk_rd_i(clk_rd_i), .rst_rd_ni(rst_rd_ni),
        .w_sram_req_i(w_sram_req_i), .w_sram_write_i(w_sram_write_i), .w_sram_addr_i(w_sram_addr_i),
        .w_sram_wdata_i(w_sram_wdata_i), .w_sram_wmask_i(w_sram_wmask_i),
        .w_sram_gnt_o(w_sram_gnt_o), .w_sram_rvalid_o(w_sram_rvalid_o),
        .w_sram_rdata_o(w_sram_rdata_o), .w_sram_rerror_o(w_sram_rerror_o),
        .r_sram_req_i(r_sram_req_i), .r_sram_write_i(r_sram_write_i), .r_sram_addr_i(r_sram_addr_i),
        .r_sram_wdata_i(r_sram_wdata_i), .r_sram_wmask_i(r_sram_wmask_i),
        .r_sram_gnt_o(r_sram_gnt_o), .r_sram_rvalid_o(r_sram_rvalid_o),
        .r_sram_rdata_o(r_sram_rdata_o), .r_sram_rerror_o(r_sram_rerror_o),
        .w_err_cnt_o(w_err_cnt_o), .r_err_cnt_o(r_err_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: array contents plus per-domain expected outputs.
    logic [31:0] mem_m [Depth];
    bit          mem_ok [Depth];
    time         wtime [Depth];

    int          wcyc = 0, w_cnt_e = 0, w_off;
    logic        w_rv_e = 0, w_dc = 0, w_acc_m;
    logic [31:0] w_rd_e = 0;
    logic [1:0]  w_re_e = 0;

    int          rcyc = 0, r_cnt_e = 0, r_off;
    logic        r_rv_e = 0, r_dc = 0, r_acc_m;
    logic [31:0] r_rd_e = 0;
    logic [1:0]  r_re_e = 0;

    initial forever begin
        @(posedge clk_wr_i or negedge rst_wr_ni);
        if (!rst_wr_ni) begin
            wcyc = 0; w_cnt_e = 0; w_rv_e = 0; w_rd_e = 0; w_re_e = 0; w_dc = 0;
        end else begin
            w_acc_m = w_sram_req_i && WrPat[wcyc % 8];
            w_off   = int'(w_sram_addr_i) - int'(Base);
            w_rv_e  = w_acc_m && !w_sram_write_i;
            w_rd_e  = 0; w_re_e = 0; w_dc = 0;
            if (w_acc_m && !(w_off >= 0 && w_off < Depth) && w_cnt_e < 255) w_cnt_e++;
            if (w_rv_e) begin
                if (w_off >= 0 && w_off < Depth) begin
                    w_rd_e = mem_m[w_off];
                    w_dc   = !mem_ok[w_off];
                end else w_re_e = 2'b10;
            end
            if (w_acc_m && w_sram_write_i && w_off >= 0 && w_off < Depth) begin
                mem_m[w_off]  = (mem_m[w_off] & ~w_sram_wmask_i) | (w_sram_wdata_i & w_sram_wmask_i);
                mem_ok[w_off] = mem_ok[w_off] || (w_sram_wmask_i == 32'hFFFF_FFFF);
                wtime[w_off]  = $time;
            end
            wcyc++;
        end
    end

    initial forever begin
        @(posedge clk_rd_i or negedge rst_rd_ni);
        if (!rst_rd_ni) begin
            rcyc = 0; r_cnt_e = 0; r_rv_e = 0; r_rd_e = 0; r_re_e = 0; r_dc = 0;
        end else begin
            r_acc_m = r_sram_req_i && RdPat[rcyc % 8];
            r_off   = int'(r_sram_addr_i) - int'(Base);
            r_rv_e  = r_acc_m && !r_sram_write_i;
            r_rd_e  = 0; r_re_e = 0; r_dc = 0;
            if (r_acc_m && (r_sram_write_i || !(r_off >= 0 && r_off < Depth)) && r_cnt_e < 255) r_cnt_e++;
            if (r_rv_e) begin
                if (r_off >= 0 && r_off < Depth) begin
                    r_rd_e = mem_m[r_off];
                    // Words written close to the sample edge are undefined across domains.
                    r_dc   = !mem_ok[r_off] || ($time - wtime[r_off] < 2 * RdPer);
                end else r_re_e = 2'b10;
            end
            rcyc++;
        end
    end

    always @(negedge clk_wr_i) begin
        chk("w_gnt", w_sram_gnt_o, WrPat[wcyc % 8]);
        chk("w_rvalid", w_sram_rvalid_o, w_rv_e);
        chk("w_rerror", w_sram_rerror_o, w_re_e);
        if (!w_dc) chk("w_rdata", w_sram_rdata_o, w_rd_e);
        chk("w_err_cnt", w_err_cnt_o, w_cnt_e);
    end

    always @(negedge clk_rd_i) begin
        chk("r_gnt", r_sram_gnt_o, RdPat[rcyc % 8]);
        chk("r_rvalid", r_sram_rvalid_o, r_rv_e);
        chk("r_rerror", r_sram_rerror_o, r_re_e);
        if (!r_dc) chk("r_rdata", r_sram_rdata_o, r_rd_e);
        chk("r_err_cnt", r_err_cnt_o, r_cnt_e);
    end

    task automatic w_acc(input logic wr, input logic [15:0] a, input logic [31:0] d, input logic [31:0] m);
        int n;
        n = 0;
        @(posedge clk_wr_i); #1;
        while (!w_sram_gnt_o && n < 16) begin @(posedge clk_wr_i); #1; n++; end
        if (n >= 16) chk("w_gnt_timeout", 32'd0, 32'd1);
        w_sram_req_i = 1; w_sram_write_i = wr; w_sram_addr_i = a; w_sram_wdata_i = d; w_sram_wmask_i = m;
        @(posedge clk_wr_i); #1;
        w_sram_req_i = 0;
    endtask

    task automatic r_acc(input logic wr, input logic [15:0] a);
        int n;
        n = 0;
        @(posedge clk_rd_i); #1;
        while (!r_sram_gnt_o && n < 16) begin @(posedge clk_rd_i); #1; n++; end
        if (n >= 16) chk("r_gnt_timeout", 32'd0, 32'd1);
        r_sram_req_i = 1; r_sram_write_i = wr; r_sram_addr_i = a;
        r_sram_wdata_i = $urandom; r_sram_wmask_i = $urandom;
        @(posedge clk_rd_i); #1;
        r_sram_req_i = 0;
    endtask

    logic [7:0] gnt_seq;
    int         gcnt;

    initial begin
        gnt_seq = 8'b1010_0101;
        #23;
        rst_wr_ni = 1; rst_rd_ni = 1;
        chk("rst_r_rvalid", r_sram_rvalid_o, 1'b0);
        chk("rst_w_rvalid", w_sram_rvalid_o, 1'b0);
        chk("rst_r_cnt", r_err_cnt_o, 8'd0);
        chk("rst_w_cnt", w_err_cnt_o, 8'd0);
        for (int i = 0; i < 16; i++) begin
            chk("rst_gnt_seq", r_sram_gnt_o, gnt_seq[i % 8]);
            @(posedge clk_rd_i); #1;
        end

        // Masked write then read-port read.
        w_acc(1, Base + 3, 32'h1234_5678, 32'hFFFF_FFFF);
        w_acc(1, Base + 3, 32'hA5A5_0000, 32'hFFFF_0000);
        repeat (4) @(posedge clk_rd_i);
        r_acc(0, Base + 3);
        chk("masked_rvalid", r_sram_rvalid_o, 1'b1);
        chk("masked_rdata", r_sram_rdata_o, 32'hA5A5_5678);
        chk("masked_rerror", r_sram_rerror_o, 2'b00);

        // Out-of-range read on the read port.
        r_acc(0, Base + Depth);
        chk("oor_rvalid", r_sram_rvalid_o, 1'b1);
        chk("oor_rdata", r_sram_rdata_o, 32'h0);
        chk("oor_rerror", r_sram_rerror_o, 2'b10);
        chk("oor_cnt", r_err_cnt_o, 8'd1);
        @(posedge clk_rd_i); #1;
        chk("oor_rvalid_1cyc", r_sram_rvalid_o, 1'b0);
        chk("oor_rdata_idle", r_sram_rdata_o, 32'h0);

        // Write-port reads and errors.
        w_acc(0, Base + 3, 0, 0);
        chk("wport_rdata", w_sram_rdata_o, 32'hA5A5_5678);
        w_acc(1, Base + Depth, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("wport_oor_wr_cnt", w_err_cnt_o, 8'd1);
        chk("wport_oor_wr_norv", w_sram_rvalid_o, 1'b0);
        w_acc(0, Base - 1, 0, 0);
        chk("wport_oor_rd_rerror", w_sram_rerror_o, 2'b10);
        chk("wport_oor_rd_cnt", w_err_cnt_o, 8'd2);

        // Throttled grant: req held 8 cycles, only granted cycles write.
        for (int i = 8; i < 16; i++) w_acc(1, Base + 16'(i), 32'hDEAD_0000 + i, 32'hFFFF_FFFF);
        gcnt = 0;
        @(posedge clk_wr_i); #1;
        for (int i = 0; i < 8; i++) begin
            w_sram_req_i = 1; w_sram_write_i = 1; w_sram_addr_i = Base + 16'(8 + i);
            w_sram_wdata_i = 32'hBEEF_0000 + i; w_sram_wmask_i = 32'hFFFF_FFFF;
            gcnt += int'(w_sram_gnt_o);
            @(posedge clk_wr_i); #1;
        end
        w_sram_req_i = 0;
        chk("throttle_grants", gcnt, 4);
        repeat (4) @(posedge clk_rd_i);
        for (int i = 8; i < 16; i++) r_acc(0, Base + 16'(i));

        // Read-port writes: no effect on array, counter saturates.
        for (int i = 0; i < 300; i++) r_acc(1, Base + 3);
        chk("sat_cnt", r_err_cnt_o, 8'hFF);
        r_acc(0, Base + 3);
        chk("sat_array_kept", r_sram_rdata_o, 32'hA5A5_5678);

        // Randomized traffic on both ports at once.
        fork
            for (int i = 0; i < 300; i++) begin
                @(posedge clk_wr_i); #1;
                w_sram_req_i   = 1'($urandom);
                w_sram_write_i = 1'($urandom);
                w_sram_addr_i  = 16'($urandom_range(int'(Base) + Depth + 1, int'(Base) - 2));
                w_sram_wdata_i = $urandom;
                w_sram_wmask_i = ($urandom_range(1, 0) != 0) ? 32'hFFFF_FFFF : $urandom;
            end
            for (int i = 0; i < 250; i++) begin
                @(posedge clk_rd_i); #1;
                r_sram_req_i   = 1'($urandom);
                r_sram_write_i = ($urandom_range(7, 0) == 0);
                r_sram_addr_i  = 16'($urandom_range(int'(Base) + Depth + 1, int'(Base) - 2));
            end
        join
        w_sram_req_i = 0; r_sram_req_i = 0;

        // Read reset right at the accepting edge; concurrent write commits.
        fork
            w_acc(1, Base + 5, 32'hCAFE_F00D, 32'hFFFF_FFFF);
            begin
                @(posedge clk_rd_i); #1;
                while (!r_sram_gnt_o) begin @(posedge clk_rd_i); #1; end
                r_sram_req_i = 1; r_sram_write_i = 0; r_sram_addr_i = Base + 2;
                @(posedge clk_rd_i);
                rst_rd_ni = 0;
                r_sram_req_i = 0;
                @(negedge clk_rd_i);
                chk("rdrst_no_rvalid", r_sram_rvalid_o, 1'b0);
                chk("rdrst_cnt", r_err_cnt_o, 8'd0);
                repeat (2) @(posedge clk_rd_i);
                #3 rst_rd_ni = 1;
            end
        join
        repeat (4) @(posedge clk_rd_i);
        r_acc(0, Base + 5);
        chk("rdrst_data_kept", r_sram_rdata_o, 32'hCAFE_F00D);
        chk("rdrst_rvalid", r_sram_rvalid_o, 1'b1);

        repeat (3) @(posedge clk_rd_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
